// File: rtl/stack_cpu_controller.sv
// Multicycle control FSM for the 8-bit stack CPU.
// Sequences fetch/decode/execute and traps stack faults into a sticky HALT.
module stack_cpu_controller #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned DEPTH_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         opcode,
  input  logic [7:0]         tos,
  input  logic [DEPTH_W-1:0] depth,
  output logic               addr_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mdr_en,
  output logic               pc_write,
  output logic               pc_src,
  output logic               load_a,
  output logic               load_b,
  output logic [1:0]         alu_control,
  output logic               stack_src,
  output logic               push,
  output logic               pop,
  output logic               instr_done,
  output logic               err,
  output logic [3:0]         state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_POP_A    = 4'd3;
  localparam logic [3:0] S_POP_B    = 4'd4;
  localparam logic [3:0] S_ALU_PUSH = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_PUSH_MDR = 4'd7;
  localparam logic [3:0] S_POP_ST   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_HALT     = 4'd15;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  typedef struct packed {
    logic       addr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_en;
    logic       pc_write;
    logic       pc_src;
    logic       load_a;
    logic       load_b;
    logic [1:0] alu_control;
    logic       stack_src;
    logic       push;
    logic       pop;
    logic       done;
  } ctrl_t;

  logic [3:0] state_q, next_state;
  ctrl_t      ctrl_q, ctrl_d;
  logic       err_q;
  logic       empty_c, jz_skip_c;

  assign empty_c   = (depth == '0);
  // Not-taken JZ retires in DECODE itself, so its done pulse depends on tos.
  assign jz_skip_c = (state_q == S_DECODE) && (opcode == OP_JZ) && !empty_c && (tos != 8'd0);

  // Next-state selection, then control decode of the state being entered
  always_comb begin
    next_state = state_q;
    ctrl_d     = '0;
    case (state_q)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND:
            next_state = (depth < DEPTH_W'(2)) ? S_HALT : S_POP_A;
          OP_NOT:  next_state = empty_c ? S_HALT : S_POP_A;
          OP_PUSH: next_state = (depth >= DEPTH_W'(STACK_DEPTH)) ? S_HALT : S_MEM_RD;
          OP_POP:  next_state = empty_c ? S_HALT : S_POP_ST;
          OP_JMP:  next_state = S_JUMP;
          OP_JZ:   next_state = empty_c ? S_HALT : ((tos == 8'd0) ? S_JUMP : S_FETCH);
          default: next_state = S_HALT;
        endcase
      end
      S_POP_A:    next_state = (opcode == OP_NOT) ? S_ALU_PUSH : S_POP_B;
      S_POP_B:    next_state = S_ALU_PUSH;
      S_ALU_PUSH: next_state = S_FETCH;
      S_MEM_RD:   next_state = S_PUSH_MDR;
      S_PUSH_MDR: next_state = S_FETCH;
      S_POP_ST:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_HALT;
    endcase

    case (next_state)
      S_FETCH: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.ir_write = 1'b1;
        ctrl_d.pc_write = 1'b1;
      end
      S_POP_A: begin
        ctrl_d.load_a = 1'b1;
        ctrl_d.pop    = 1'b1;
      end
      S_POP_B: begin
        ctrl_d.load_b = 1'b1;
        ctrl_d.pop    = 1'b1;
      end
      S_ALU_PUSH: begin
        ctrl_d.alu_control = opcode[1:0];
        ctrl_d.push        = 1'b1;
        ctrl_d.done        = 1'b1;
      end
      S_MEM_RD: begin
        ctrl_d.addr_src = 1'b1;
        ctrl_d.mem_read = 1'b1;
        ctrl_d.mdr_en   = 1'b1;
      end
      S_PUSH_MDR: begin
        ctrl_d.stack_src = 1'b1;
        ctrl_d.push      = 1'b1;
        ctrl_d.done      = 1'b1;
      end
      S_POP_ST: begin
        ctrl_d.addr_src  = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.pop       = 1'b1;
        ctrl_d.done      = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_write = 1'b1;
        ctrl_d.pc_src   = 1'b1;
        ctrl_d.done     = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // State, registered controls and sticky fault flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= next_state;
      ctrl_q  <= ctrl_d;
      err_q   <= err_q | (next_state == S_HALT);
    end
  end

  assign addr_src    = ctrl_q.addr_src;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign ir_write    = ctrl_q.ir_write;
  assign mdr_en      = ctrl_q.mdr_en;
  assign pc_write    = ctrl_q.pc_write;
  assign pc_src      = ctrl_q.pc_src;
  assign load_a      = ctrl_q.load_a;
  assign load_b      = ctrl_q.load_b;
  assign alu_control = ctrl_q.alu_control;
  assign stack_src   = ctrl_q.stack_src;
  assign push        = ctrl_q.push;
  assign pop         = ctrl_q.pop;
  assign instr_done  = ctrl_q.done | jz_skip_c;
  assign err         = err_q;
  assign state       = state_q;

endmodule
